masked_serial_add_ctrl: RTL and testbench
=========================================

Name: masked_serial_add_ctrl

Overview:
- Bit-serial controller for a 2-share Boolean-masked adder of WIDTH bits.
- Per cycle, it sequences one bit position through a masked full adder. The full adder is two existing half_adder_masked gadgets; carry-out = XOR of the two gadget carries, since those carries are mutually exclusive.
- It gates progress on availability of fresh randomness and handles valid/ready handshakes on both sides.
- Outputs are registered (PROLEAD-compatible). Shares are never recombined inside the block.

Parameters:
- WIDTH, 4: operand/result bit width; legal range 1..32.
- CNT_W, $clog2(WIDTH) (min 1): bit-index counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  operand pair valid.
- o_ready  out  1  block can accept operands.
- i_A0, i_A1  in  WIDTH  shares of operand A (A = A0^A1).
- i_B0, i_B1  in  WIDTH  shares of operand B.
- i_rnd  in  2  fresh random bits for this step: [0] drives the first gadget's rN, [1] the second's.
- i_rnd_valid  in  1  i_rnd holds fresh bits this cycle.
- o_rnd_req  out  1  controller consumes randomness this cycle if i_rnd_valid.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_SUM0, o_SUM1  out  WIDTH  shares of (A+B) mod 2^WIDTH.
- o_CARRY0, o_CARRY1  out  1  shares of the final carry-out.

Behaviour:
- Reset (async, any state):
  - state=IDLE, counter=0.
  - All operand, carry and result share registers = 0.
  - o_ready=1, o_valid=0, o_rnd_req=0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - o_ready=1.
  - On i_valid&o_ready: capture the four operand shares into shift registers, clear carry shares to 0, counter=0, go to RUN.
- RUN:
  - o_rnd_req=1, o_ready=0.
  - Cycle with i_rnd_valid=1 (a step): process bit position counter, LSB first, using operand share bits 0 of the shift registers and the current carry shares.
    - Shift the sum shares into the result registers at the MSB end (right shift), so after WIDTH steps bit i sits at index i.
    - Update carry shares; shift the operand registers right; counter++.
  - Cycle with i_rnd_valid=0: full stall; no register changes. Randomness is never reused across steps.
  - Step with counter==WIDTH-1: final carry shares go to o_CARRY0/1; next state is DONE.
- DONE:
  - o_valid=1; o_SUM*/o_CARRY* held stable.
  - On i_ready: o_valid=0 next cycle, operand shift registers zeroized, go to IDLE.
  - Result registers retain their last value until overwritten by the next operation.
- Latency, handshake cycle to o_valid:
  - WIDTH + (number of stalled RUN cycles) cycles.
  - Back-to-back minimum period is WIDTH+2 cycles.
- No overlap: i_valid ignored outside IDLE; i_rnd/i_rnd_valid ignored outside RUN.
- Mask correctness:
  - Invariant: SUM0^SUM1 = A+B (mod 2^WIDTH) and CARRY0^CARRY1 = carry-out, for any operand share split and any i_rnd sequence.
  - Individual shares depend on i_rnd.
- Reset mid-RUN or mid-DONE: immediate return to the reset state; the partial result is discarded and never flagged valid.
- WIDTH=1: a single step, then DONE.

Decomposition:
- Package masked_add_pkg: state enum (IDLE, RUN, DONE), WIDTH default, share-pair struct typedef.
- Sub-module masked_full_adder (combinational):
  - Two half_adder_masked instances, each with its own rN bit from i_rnd.
  - Sum shares = second gadget's SUM shares.
  - Carry shares = share-wise XOR of both gadgets' CARRY shares.
- The controller instantiates exactly one masked_full_adder.

Test Plan:
- WIDTH=4, A0=0x5, A1=0xC, B0=0x3, B1=0xB, i_rnd_valid=1 constantly:
  - o_valid 4 cycles after the handshake.
  - o_SUM0^o_SUM1=0x1, o_CARRY0^o_CARRY1=1 (9+8=17).
- Operands A=0xF, B=0xF (A0=0xA, A1=0x5, B0=0x6, B1=0x9), i_rnd_valid low for 3 mid-RUN cycles:
  - o_valid 7 cycles after the handshake.
  - Unmasked SUM=0xE, CARRY=1.
  - o_rnd_req stays 1 throughout.
- Same operands repeated with two different i_rnd sequences:
  - Identical unmasked results (SUM=0x1, CARRY=1).
  - Differing individual shares.
- Backpressure: i_ready=0 for 5 cycles in DONE:
  - o_valid and outputs stable.
  - o_ready=0; i_valid pulses ignored.
  - After i_ready=1, IDLE and o_ready=1 next cycle.
- Assert rst at RUN step 2:
  - All outputs 0 and state IDLE without waiting for a clock edge.
  - Next operation A=0x0, B=0x0 yields SUM=0x0, CARRY=0.
- Back-to-back: the second i_valid is held from the first acceptance; it is accepted only in the IDLE cycle after the first result is consumed, giving a period of 6 cycles.

Source files
------------

// File: rtl/masked_add_pkg.sv
// Shared types and constants for the bit-serial masked adder.
package masked_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Controller states.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // One bit held as two Boolean shares (value = s0 ^ s1).
  typedef struct packed {
    logic s0;
    logic s1;
  } share_pair_t;

endpackage

// File: rtl/half_adder_masked.sv
// Two-share masked half adder: sum is share-wise XOR, carry is a
// domain-oriented masked AND refreshed with one fresh random bit.
module half_adder_masked (
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic rn,
  output logic sum0,
  output logic sum1,
  output logic carry0,
  output logic carry1
);

  // Cross-domain products are blinded by rn before joining the other share.
  always_comb begin
    sum0   = a0 ^ b0;
    sum1   = a1 ^ b1;
    carry0 = (a0 & b0) ^ ((a0 & b1) ^ rn);
    carry1 = (a1 & b1) ^ ((a1 & b0) ^ rn);
  end

endmodule

// File: rtl/masked_full_adder.sv
// Masked full adder built from two masked half adders. The two gadget
// carries can never both be 1, so their XOR equals the true carry-out.
module masked_full_adder
  import masked_add_pkg::*;
(
  input  logic        a0,
  input  logic        a1,
  input  logic        b0,
  input  logic        b1,
  input  share_pair_t cin,
  input  logic [1:0]  rnd,
  output share_pair_t sum,
  output share_pair_t cout
);

  logic p0, p1, g0, g1;
  logic s0, s1, h0, h1;

  half_adder_masked u_ha_ab (
    .a0     (a0),
    .a1     (a1),
    .b0     (b0),
    .b1     (b1),
    .rn     (rnd[0]),
    .sum0   (p0),
    .sum1   (p1),
    .carry0 (g0),
    .carry1 (g1)
  );

  half_adder_masked u_ha_pc (
    .a0     (p0),
    .a1     (p1),
    .b0     (cin.s0),
    .b1     (cin.s1),
    .rn     (rnd[1]),
    .sum0   (s0),
    .sum1   (s1),
    .carry0 (h0),
    .carry1 (h1)
  );

  // Combine gadget outputs share-wise; shares are never recombined.
  always_comb begin
    sum.s0  = s0;
    sum.s1  = s1;
    cout.s0 = g0 ^ h0;
    cout.s1 = g1 ^ h1;
  end

endmodule

// File: rtl/masked_serial_add_ctrl.sv
// Bit-serial controller for a 2-share Boolean-masked adder. One bit
// position per step, LSB first, advancing only when fresh randomness
// is offered. Results and carry-out are held in registers until consumed.
module masked_serial_add_ctrl
  import masked_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_A0,
  input  logic [WIDTH-1:0] i_A1,
  input  logic [WIDTH-1:0] i_B0,
  input  logic [WIDTH-1:0] i_B1,
  input  logic [1:0]       i_rnd,
  input  logic             i_rnd_valid,
  output logic             o_rnd_req,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_SUM0,
  output logic [WIDTH-1:0] o_SUM1,
  output logic             o_CARRY0,
  output logic             o_CARRY1
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] a0_sr, a1_sr, b0_sr, b1_sr;
  share_pair_t      carry;
  logic [WIDTH-1:0] sum0_r, sum1_r;
  logic             cout0_r, cout1_r;

  share_pair_t      fa_sum, fa_cout;

  masked_full_adder u_fa (
    .a0   (a0_sr[0]),
    .a1   (a1_sr[0]),
    .b0   (b0_sr[0]),
    .b1   (b1_sr[0]),
    .cin  (carry),
    .rnd  (i_rnd),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Sequencing, operand shifting and result accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      a0_sr   <= '0;
      a1_sr   <= '0;
      b0_sr   <= '0;
      b1_sr   <= '0;
      carry   <= '0;
      sum0_r  <= '0;
      sum1_r  <= '0;
      cout0_r <= 1'b0;
      cout1_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a0_sr   <= i_A0;
            a1_sr   <= i_A1;
            b0_sr   <= i_B0;
            b1_sr   <= i_B1;
            carry   <= '0;
            counter <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          // Without fresh randomness nothing moves, so no bit is ever reused.
          if (i_rnd_valid) begin
            sum0_r  <= (sum0_r >> 1) | (WIDTH'(fa_sum.s0) << (WIDTH - 1));
            sum1_r  <= (sum1_r >> 1) | (WIDTH'(fa_sum.s1) << (WIDTH - 1));
            carry   <= fa_cout;
            a0_sr   <= a0_sr >> 1;
            a1_sr   <= a1_sr >> 1;
            b0_sr   <= b0_sr >> 1;
            b1_sr   <= b1_sr >> 1;
            counter <= counter + CNT_W'(1);
            if (counter == LAST_IDX) begin
              cout0_r <= fa_cout.s0;
              cout1_r <= fa_cout.s1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          if (i_ready) begin
            a0_sr <= '0;
            a1_sr <= '0;
            b0_sr <= '0;
            b1_sr <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    o_ready   = (state == IDLE);
    o_rnd_req = (state == RUN);
    o_valid   = (state == DONE);
    o_SUM0    = sum0_r;
    o_SUM1    = sum1_r;
    o_CARRY0  = cout0_r;
    o_CARRY1  = cout1_r;
  end

endmodule

// File: tb/tb_masked_serial_add_ctrl.sv
// Self-checking bench for masked_serial_add_ctrl (WIDTH=4): directed
// scenarios plus a randomized run, all compared against an unmasked model.
module tb_masked_serial_add_ctrl;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid, o_ready;
  logic [WIDTH-1:0] i_A0, i_A1, i_B0, i_B1;
  logic [1:0]       i_rnd;
  logic             i_rnd_valid, o_rnd_req;
  logic             o_valid, i_ready;
  logic [WIDTH-1:0] o_SUM0, o_SUM1;
  logic             o_CARRY0, o_CARRY1;

  int checks = 0;
  int errors = 0;

  masked_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_A0        (i_A0),
    .i_A1        (i_A1),
    .i_B0        (i_B0),
    .i_B1        (i_B1),
    .i_rnd       (i_rnd),
    .i_rnd_valid (i_rnd_valid),
    .o_rnd_req   (o_rnd_req),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_SUM0      (o_SUM0),
    .o_SUM1      (o_SUM1),
    .o_CARRY0    (o_CARRY0),
    .o_CARRY1    (o_CARRY1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  function automatic int unsigned add_ops(input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                                          input logic [WIDTH-1:0] b0, input logic [WIDTH-1:0] b1);
    return int'(a0 ^ a1) + int'(b0 ^ b1);
  endfunction

  // Unmasked model: busy for WIDTH randomness-fed cycles, then holds the result.
  logic             m_run, m_done;
  int               m_steps;
  logic [WIDTH-1:0] m_sum;
  logic             m_carry;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run   <= 1'b0;
      m_done  <= 1'b0;
      m_steps <= 0;
      m_sum   <= '0;
      m_carry <= 1'b0;
    end else if (m_done) begin
      if (i_ready) m_done <= 1'b0;
    end else if (m_run) begin
      if (i_rnd_valid) begin
        m_steps <= m_steps + 1;
        if (m_steps == WIDTH - 1) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end else if (i_valid) begin
      m_run   <= 1'b1;
      m_steps <= 0;
      m_sum   <= WIDTH'(add_ops(i_A0, i_A1, i_B0, i_B1));
      m_carry <= (add_ops(i_A0, i_A1, i_B0, i_B1) >> WIDTH) != 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("o_ready", o_ready, !m_run && !m_done);
      check("o_valid", o_valid, m_done);
      check("o_rnd_req", o_rnd_req, m_run);
      if (m_done) begin
        check("sum_unmasked", o_SUM0 ^ o_SUM1, m_sum);
        check("carry_unmasked", o_CARRY0 ^ o_CARRY1, m_carry);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation from IDLE and wait for o_valid; stalls cover RUN cycles lo..hi.
  task automatic run_op(input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                        input logic [WIDTH-1:0] b0, input logic [WIDTH-1:0] b1,
                        input bit fixed_rnd, input logic [1:0] rnd_val,
                        input int stall_lo, input int stall_hi, output int lat);
    check("ready_before_op", o_ready, 1);
    i_A0 = a0; i_A1 = a1; i_B0 = b0; i_B1 = b1;
    i_valid = 1'b1; i_ready = 1'b0; i_rnd_valid = 1'b0;
    tick();
    i_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 100 && !o_valid; k++) begin
      i_rnd_valid = !(k >= stall_lo && k <= stall_hi);
      i_rnd = fixed_rnd ? rnd_val : 2'($urandom);
      tick();
      lat++;
    end
    i_rnd_valid = 1'b0;
    check("valid_within_bound", o_valid, 1);
  endtask

  task automatic consume();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("idle_after_consume_ready", o_ready, 1);
    check("idle_after_consume_valid", o_valid, 0);
  endtask

  int               lat;
  logic [WIDTH-1:0] s0, s1, s0a, s0b;
  logic             c0, c1;
  logic [WIDTH-1:0] r, q;
  int               first_acc, second_acc;

  initial begin
    rst = 1'b1;
    i_valid = 1'b0; i_rnd_valid = 1'b0; i_ready = 1'b0; i_rnd = '0;
    i_A0 = '0; i_A1 = '0; i_B0 = '0; i_B1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_rnd_req", o_rnd_req, 0);
    check("rst_sum0", o_SUM0, 0);
    check("rst_sum1", o_SUM1, 0);
    check("rst_carry", {o_CARRY0, o_CARRY1}, 0);
    rst = 1'b0;
    tick();

    // 9 + 8 = 17 with randomness always available.
    run_op(4'h5, 4'hC, 4'h3, 4'hB, 1'b0, 2'b00, -1, -2, lat);
    check("t1_latency", lat, 4);
    check("t1_sum", o_SUM0 ^ o_SUM1, 4'h1);
    check("t1_carry", o_CARRY0 ^ o_CARRY1, 1);
    check("t1_model_sum", m_sum, 4'h1);

    // Backpressure in DONE with stray i_valid pulses.
    s0 = o_SUM0; s1 = o_SUM1; c0 = o_CARRY0; c1 = o_CARRY1;
    for (int i = 0; i < 5; i++) begin
      i_valid = (i % 2) == 1;
      tick();
      check("bp_valid", o_valid, 1);
      check("bp_ready", o_ready, 0);
      check("bp_sum0_stable", o_SUM0, s0);
      check("bp_sum1_stable", o_SUM1, s1);
      check("bp_carry_stable", {o_CARRY0, o_CARRY1}, {c0, c1});
    end
    i_valid = 1'b0;
    consume();

    // 15 + 15 = 30 with three stalled RUN cycles.
    run_op(4'hA, 4'h5, 4'h6, 4'h9, 1'b0, 2'b00, 1, 3, lat);
    check("t2_latency", lat, 7);
    check("t2_sum", o_SUM0 ^ o_SUM1, 4'hE);
    check("t2_carry", o_CARRY0 ^ o_CARRY1, 1);
    consume();

    // Same operands, two randomness sequences.
    run_op(4'h5, 4'hC, 4'h3, 4'hB, 1'b1, 2'b00, -1, -2, lat);
    s0a = o_SUM0;
    check("t3a_sum", o_SUM0 ^ o_SUM1, 4'h1);
    check("t3a_carry", o_CARRY0 ^ o_CARRY1, 1);
    consume();
    run_op(4'h5, 4'hC, 4'h3, 4'hB, 1'b1, 2'b01, -1, -2, lat);
    s0b = o_SUM0;
    check("t3b_sum", o_SUM0 ^ o_SUM1, 4'h1);
    check("t3b_carry", o_CARRY0 ^ o_CARRY1, 1);
    check("t3_shares_differ", s0a != s0b, 1);
    consume();

    // Asynchronous reset after two RUN steps.
    i_A0 = 4'h7; i_A1 = 4'h2; i_B0 = 4'hD; i_B1 = 4'h4;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_rnd_valid = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_sum0", o_SUM0, 0);
    check("arst_sum1", o_SUM1, 0);
    check("arst_carry", {o_CARRY0, o_CARRY1}, 0);
    check("arst_valid", o_valid, 0);
    check("arst_ready", o_ready, 1);
    check("arst_rnd_req", o_rnd_req, 0);
    i_rnd_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    r = 4'($urandom);
    q = 4'($urandom);
    run_op(r, r, q, q, 1'b0, 2'b00, -1, -2, lat);
    check("zero_sum", o_SUM0 ^ o_SUM1, 0);
    check("zero_carry", o_CARRY0 ^ o_CARRY1, 0);
    consume();

    // Back-to-back with i_valid held and the consumer always ready.
    i_A0 = 4'($urandom); i_A1 = 4'($urandom); i_B0 = 4'($urandom); i_B1 = 4'($urandom);
    i_valid = 1'b1; i_ready = 1'b1; i_rnd_valid = 1'b1;
    first_acc = -1; second_acc = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (o_ready && i_valid) begin
        if (first_acc < 0) first_acc = cyc;
        else if (second_acc < 0) second_acc = cyc;
      end
      i_rnd = 2'($urandom);
      tick();
    end
    check("b2b_period", second_acc - first_acc, 6);
    i_valid = 1'b0;
    for (int k = 0; k < 50 && !o_ready; k++) tick();
    i_ready = 1'b0; i_rnd_valid = 1'b0;
    check("b2b_drained", o_ready, 1);

    // Randomized traffic checked by the per-cycle compare.
    for (int n = 0; n < 800; n++) begin
      i_valid     = ($urandom % 3) == 0;
      i_A0        = 4'($urandom);
      i_A1        = 4'($urandom);
      i_B0        = 4'($urandom);
      i_B1        = 4'($urandom);
      i_rnd       = 2'($urandom);
      i_rnd_valid = ($urandom % 4) != 0;
      i_ready     = ($urandom % 2) == 0;
      tick();
    end
    i_valid = 1'b0; i_rnd_valid = 1'b1; i_ready = 1'b1;
    for (int k = 0; k < 50 && !o_ready; k++) tick();
    check("rand_drained", o_ready, 1);
    i_rnd_valid = 1'b0; i_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
